uart_serializer: RTL
====================

// Module: uart_serializer
// PURPOSE
//   Serial transmit stage behind the memory-mapped IO block's output byte
//   buffer. Takes one byte per valid/busy handshake and shifts it out LSB-first
//   as an 8N1 UART frame: start bit, DATA_BITS data bits, STOP_BITS stop bits.
//   Reports busy and a one-cycle done pulse; the buffer uses both to pace pops.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per baud period (115200 baud @ 50 MHz); must be >= 2
//   DATA_BITS     8    data bits per frame, 5..8; upper tx_byte bits ignored
//   STOP_BITS     1    stop bits per frame, 1 or 2
// PORTS
//   clk        in   1  clock, all logic on posedge
//   reset      in   1  synchronous, active-low
//   tx_valid   in   1  request to send tx_byte; sampled only in IDLE
//   tx_byte    in   8  byte to send; captured on the accepting edge
//   tx_busy    out  1  high from the accepting edge through the last stop-bit cycle
//   tx_done    out  1  single-cycle pulse after the last stop bit
//   tx_serial  out  1  UART line, idle high; registered output, no glitches
// BEHAVIOUR
//   - Reset (reset==0 at posedge): state=IDLE, tx_serial=1, tx_busy=0,
//     tx_done=0, counters=0. Takes priority over everything, including mid-frame.
//     A frame cut off by reset is abandoned. The line is high on the next cycle.
//     The frame is never resumed.
//   - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> DONE -> IDLE.
//   - IDLE: tx_serial=1. If tx_valid=1 at posedge: latch tx_byte into the shift
//     register, go to START, and register tx_busy=1, tx_serial=0 on that edge.
//   - START, DATA, PARITY, STOP: each bit holds for exactly CLKS_PER_BIT cycles.
//     The baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1,
//     and wraps to 0 on each bit transition.
//   - DATA: sends bit index 0..DATA_BITS-1, LSB first. The index counter is
//     3 bits wide.
//   - STOP: drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - DONE: lasts one cycle. tx_busy=0, tx_done=1, tx_serial=1. tx_valid is
//     ignored in DONE, so no frame can start during the done pulse.
//   - tx_valid is ignored while tx_busy=1. tx_byte changes mid-frame have no
//     effect.
//   - Frame length, busy high: (1 + DATA_BITS + STOP_BITS) * CLKS_PER_BIT cycles,
//     plus CLKS_PER_BIT more when parity is enabled.
//   - Minimum accept-to-accept spacing = frame length + 2 cycles (1 DONE + 1 IDLE).
//   - tx_busy and tx_done are never high in the same cycle.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - Adds a PARITY state after DATA, lasting CLKS_PER_BIT cycles.
//     - Drives even parity: XOR of the DATA_BITS data bits sent.
//     - Frame becomes 8E1.
//   UART_TX_PARITY_EN undefined:
//     - PARITY state and XOR logic are absent. DATA goes straight to STOP.
//   The far-end receiver must be built with the matching setting.
// TESTING (bench CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated)
//   1. Reset low 3 cycles, then high, tx_valid=0
//      -> tx_serial=1, tx_busy=0, tx_done=0 throughout.
//   2. tx_valid=1 for 1 cycle, tx_byte=8'h55
//      -> tx_serial shows 0,1,0,1,0,1,0,1,0,1, each level for 4 cycles.
//      -> tx_busy high for 40 cycles, then tx_done high for exactly 1 cycle.
//   3. tx_valid held high, bytes 8'hA3 then 8'h0F
//      -> both frames are correct. The second start bit falls 42 cycles after
//         the first. tx_valid during busy and DONE causes no extra frame.
//   4. Reset driven low 15 cycles into a frame of 8'h00
//      -> next cycle tx_serial=1, tx_busy=0, no tx_done pulse.
//      -> a new 8'hFF frame then completes normally.
//   5. UART_TX_PARITY_EN defined, tx_byte=8'h07
//      -> parity bit 1 after data bit 7. tx_busy lasts 44 cycles.
//      -> with tx_byte=8'h03, the parity bit is 0.
//   6. STOP_BITS=2, tx_byte=8'h80
//      -> stop level held 8 cycles, tx_busy lasts 44 cycles, tx_done lands on
//         cycle 45.

Source files
------------

// File: rtl/uart_serializer_if.sv
// Byte handshake between the output byte buffer and the UART serializer.
// The buffer drives tx_valid/tx_byte; the serializer reports busy, done and the line.
interface uart_serializer_if;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_serial;

  modport master (output tx_valid, output tx_byte,
                  input  tx_busy, input tx_done, input tx_serial);
  modport slave  (input  tx_valid, input tx_byte,
                  output tx_busy, output tx_done, output tx_serial);
endinterface

// File: rtl/uart_serializer.sv
// 8N1 UART transmit stage: one byte per handshake, shifted out LSB-first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_serializer_if.slave  bus
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]     LAST_STOP = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          busy;
  logic          done;
  logic          line;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  assign bus.tx_busy   = busy;
  assign bus.tx_done   = done;
  assign bus.tx_serial = line;

  // bit_idx counts data bits in DATA and stop bits in STOP; every bit holds CLKS_PER_BIT cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      line      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          line     <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (bus.tx_valid) begin
            shift_reg <= bus.tx_byte;
            state     <= START;
            busy      <= 1'b1;
            line      <= 1'b0;
          end
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= DATA;
            line      <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
`ifdef UART_TX_PARITY_EN
            parity    <= shift_reg[0];
`endif
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              line    <= parity;
`else
              state   <= STOP;
              line    <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              line      <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
`ifdef UART_TX_PARITY_EN
              parity    <= parity ^ shift_reg[0];
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= STOP;
            line     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          line <= 1'b1;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        // tx_valid is deliberately not sampled here so no frame starts during the done pulse
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          line  <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          line  <= 1'b1;
        end
      endcase
    end
  end

endmodule
